fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the asynchronous FIFO among NREQ requesters.
- Sits entirely in the write clock domain and drives the FIFO's winc/wdata from the granted requester, honouring wfull.
- Grants are packet-oriented: a grant is held until the requester's last word, or until MAXBURST words, whichever comes first. This bounds latency for the other requesters.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DSIZE, 8, data width; matches the FIFO DSIZE
- MAXBURST, 4, maximum words transferred per grant before forced rotation (1..16)

Ports:
- wclk  input  1  write-domain clock; all logic is on the rising edge
- wrst_n  input  1  reset; one clock; reset is synchronous and active-low
- req_valid  input  NREQ  per-requester word-valid
- req_data  input  NREQ*DSIZE  per-requester data; requester k occupies bits [k*DSIZE +: DSIZE]
- req_last  input  NREQ  per-requester end-of-packet marker, qualified by req_valid
- req_ready  output  NREQ  per-requester accept; at most one bit is high
- winc  output  1  FIFO write enable
- wdata  output  DSIZE  FIFO write data
- wfull  input  1  FIFO full flag
- gnt_valid  output  1  a grant is active (state BURST)
- gnt_id  output  clog2(NREQ)  index of the granted requester; holds its last value when gnt_valid=0

Behaviour:
- Reset (wrst_n=0 at a wclk edge) sets:
  - state=IDLE, rr pointer=0, burst count=0, gnt_id=0, gnt_valid=0
  - winc, req_ready and wdata are then 0, because their combinational terms are gated by state.
- Reset is honoured mid-burst. A partially sent packet is abandoned, and the requester must resend or continue after reset.
- State IDLE:
  - If any req_valid is set, pick the first set bit searching from the rr pointer upward with wrap (NREQ-1 wraps to 0).
  - Register gnt_id, set gnt_valid, clear count, go to BURST.
  - Arbitration costs exactly one bubble cycle; no transfer occurs in IDLE.
- State BURST, transfer condition xfer = req_valid[gnt_id] & ~wfull:
  - req_ready[gnt_id] = ~wfull; all other ready bits are 0.
  - winc = xfer; wdata = req_data[gnt_id] (0 when winc=0).
  - Transfer is zero-latency: the word is written into the FIFO on the same wclk edge it is accepted.
- Exit BURST: on an xfer cycle with req_last[gnt_id]=1, or with count==MAXBURST-1, go to IDLE and set the rr pointer to (gnt_id+1) mod NREQ. Otherwise increment count on each xfer.
- If the granted requester drops req_valid, the grant is held (stall) with no timeout. Requesters must complete packets.
- wfull=1: winc is never asserted, count does not advance, no word is lost or duplicated, and the grant is held.
- A MAXBURST cut splits a packet. The requester re-arbitrates for the remainder, and its next granted word continues the packet.
- Requests arriving during BURST wait; fairness is round-robin across grants.
- count width is clog2(MAXBURST)+1; there are no other arithmetic paths.

Decomposition:
- Package fifo_arb_pkg holds:
  - the state enum {IDLE, BURST}
  - the localparam IDW = clog2(NREQ)
  - the function rr_next(ptr), implementing mod-NREQ increment.
- One sub-module, rr_pick: combinational; inputs req vector and pointer; outputs found flag and index. It implements the rotate / priority-encode / unrotate search.

Test Plan (NREQ=4, DSIZE=8, MAXBURST=4):
1. Reset:
   - Stimulus: hold wrst_n=0 for 2 wclk with all req_valid=1.
   - Required: winc=0, req_ready=0000, gnt_valid=0.
   - After release: first grant is gnt_id=0.
2. Single packet:
   - Stimulus: requester 2 presents 0xA1, 0xA2, 0xA3 with last on 0xA3; wfull=0.
   - Required: gnt_id=2 after 1 bubble cycle, then winc=1 for 3 consecutive cycles with wdata A1, A2, A3, then gnt_valid=0.
3. Fairness:
   - Stimulus: all four requesters continuously send single-word packets (last=1).
   - Required: grant order 0, 1, 2, 3, 0, 1; one FIFO write every 2 cycles.
4. Backpressure:
   - Stimulus: wfull=1 for 5 cycles after the 1st of 3 words from requester 1.
   - Required: winc=0 and req_ready[1]=0 for all 5 cycles; words 2 and 3 written in order once wfull=0.
5. Burst cut:
   - Stimulus: requester 1 sends 6 words 0x10..0x15 (last on 0x15) while requester 3 is valid.
   - Required: writes 0x10..0x13, then requester 3's packet, then 0x14, 0x15.
6. Reset mid-burst:
   - Stimulus: assert wrst_n=0 after word 2 of a 4-word packet from requester 2.
   - Required: winc=0 on the next cycle, gnt_valid=0, and the next grant starts from pointer 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Grant-index width for the default four-requester build.
    localparam int NREQ_DFLT = 4;
    localparam int IDW       = $clog2(NREQ_DFLT);

    function automatic int rr_next(input int ptr, input int nreq);
        return (ptr >= nreq - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin search: first set request at or above ptr, wrapping past N-1.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    localparam logic [W:0] NV = (W+1)'(N);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [W-1:0]   pe;
    logic [W:0]     sum;

    always_comb begin
        // Rotate so the pointer position lands at bit 0, encode, then undo.
        dbl = {req, req};
        rot = N'(dbl >> ptr);
        pe  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) pe = W'(i);
        end
        sum = {1'b0, ptr} + {1'b0, pe};
        if (sum >= NV) sum = sum - NV;
        idx   = sum[W-1:0];
        found = |req;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-oriented round-robin arbiter sharing one async-FIFO write port.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ     = NREQ_DFLT,
    parameter int DSIZE    = 8,
    parameter int MAXBURST = 4
) (
    input  logic                    wclk,
    input  logic                    wrst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DSIZE-1:0]   req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    output logic                    winc,
    output logic [DSIZE-1:0]        wdata,
    input  logic                    wfull,
    output logic                    gnt_valid,
    output logic [$clog2(NREQ)-1:0] gnt_id
);

    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(MAXBURST) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(MAXBURST - 1);

    arb_state_t     state, state_n;
    logic [GW-1:0]  rr_ptr, rr_ptr_n, gnt_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic           found;
    logic [GW-1:0]  pick;
    logic           sel_valid, sel_last, xfer;
    logic [DSIZE-1:0] sel_data;

    rr_pick #(.N(NREQ), .W(GW)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .found (found),
        .idx   (pick)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_id == GW'(k)) begin
                sel_valid    = req_valid[k];
                sel_last     = req_last[k];
                sel_data     = req_data[k*DSIZE +: DSIZE];
                req_ready[k] = gnt_valid & ~wfull;
            end
        end
    end

    // Word moves straight through to the FIFO on the accepting edge.
    assign gnt_valid = (state == BURST);
    assign xfer      = gnt_valid & sel_valid & ~wfull;
    assign winc      = xfer;
    assign wdata     = xfer ? sel_data : '0;

    always_comb begin
        state_n  = state;
        rr_ptr_n = rr_ptr;
        gnt_n    = gnt_id;
        cnt_n    = cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_n   = pick;
                    cnt_n   = '0;
                    state_n = BURST;
                end
            end
            BURST: begin
                if (xfer) begin
                    if (sel_last || cnt == LAST_CNT) begin
                        state_n  = IDLE;
                        rr_ptr_n = GW'(rr_next(int'(gnt_id), NREQ));
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
            gnt_id <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_n;
            rr_ptr <= rr_ptr_n;
            gnt_id <= gnt_n;
            cnt    <= cnt_n;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: per-requester word queues feed a packet-level model.
module tb_fifo_wr_arbiter;

    localparam int NREQ     = 4;
    localparam int DSIZE    = 8;
    localparam int MAXBURST = 4;
    localparam int IDW      = 2;

    logic                  wclk = 1'b0;
    logic                  wrst_n = 1'b0;
    logic [NREQ-1:0]       req_valid, req_last, req_ready;
    logic [NREQ*DSIZE-1:0] req_data;
    logic                  winc, wfull, gnt_valid;
    logic [DSIZE-1:0]      wdata;
    logic [IDW-1:0]        gnt_id;

    fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAXBURST(MAXBURST)) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .winc      (winc),
        .wdata     (wdata),
        .wfull     (wfull),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always #5 wclk = ~wclk;

    int n_cmp = 0;
    int n_err = 0;

    logic [DSIZE-1:0] qd [NREQ][$];
    bit               ql [NREQ][$];

    bit m_busy  = 1'b0;
    int m_id    = 0;
    int m_ptr   = 0;
    int m_words = 0;

    int valid_pct  = 100;
    int full_pct   = 0;
    bit force_full = 1'b0;
    bit chk_en     = 1'b0;
    int cyc        = 0;

    int log_id[$];
    int log_dat[$];
    int log_cyc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_pkt(input int k, input int n, input int base);
        for (int i = 0; i < n; i++) begin
            qd[k].push_back(DSIZE'(base + i));
            ql[k].push_back(i == n - 1);
        end
    endtask

    function automatic bit pending();
        bit p = m_busy;
        for (int k = 0; k < NREQ; k++) if (qd[k].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic clear_log();
        log_id.delete();
        log_dat.delete();
        log_cyc.delete();
    endtask

    task automatic step(input bit rst_lvl);
        bit               e_xfer, fin;
        logic [NREQ-1:0]  e_rdy;
        logic [DSIZE-1:0] e_wd;
        @(negedge wclk);
        wrst_n = rst_lvl;
        for (int k = 0; k < NREQ; k++) begin
            if (qd[k].size() > 0 && $urandom_range(99) < valid_pct) begin
                req_valid[k] = 1'b1;
                req_data[k*DSIZE +: DSIZE] = qd[k][0];
                req_last[k] = ql[k][0];
            end else begin
                req_valid[k] = 1'b0;
                req_data[k*DSIZE +: DSIZE] = DSIZE'($urandom);
                req_last[k] = 1'($urandom_range(1));
            end
        end
        wfull = force_full || ($urandom_range(99) < full_pct);
        #1;
        e_xfer = m_busy && req_valid[m_id] && !wfull;
        e_rdy  = '0;
        if (m_busy && !wfull) e_rdy[m_id] = 1'b1;
        e_wd   = '0;
        if (e_xfer) e_wd = qd[m_id][0];
        if (chk_en) begin
            check("gnt_valid", gnt_valid, m_busy);
            check("gnt_id", gnt_id, m_id);
            check("winc", winc, e_xfer);
            check("req_ready", req_ready, e_rdy);
            check("wdata", wdata, e_wd);
        end
        if (winc) begin
            log_id.push_back(int'(gnt_id));
            log_dat.push_back(int'(wdata));
            log_cyc.push_back(cyc);
        end
        cyc++;
        // Advance the model to what holds after this rising edge.
        fin = 1'b0;
        if (e_xfer) begin
            m_words++;
            fin = ql[m_id][0] || (m_words == MAXBURST);
            void'(qd[m_id].pop_front());
            void'(ql[m_id].pop_front());
        end
        if (!rst_lvl) begin
            m_busy = 1'b0; m_id = 0; m_ptr = 0; m_words = 0;
        end else if (!m_busy) begin
            if (req_valid != '0) begin
                for (int off = NREQ - 1; off >= 0; off--)
                    if (req_valid[(m_ptr + off) % NREQ]) m_id = (m_ptr + off) % NREQ;
                m_busy  = 1'b1;
                m_words = 0;
            end
        end else if (fin) begin
            m_busy = 1'b0;
            m_ptr  = (m_id + 1) % NREQ;
        end
    endtask

    task automatic drain(input string tag, input int max);
        int n = 0;
        while (pending() && n < max) begin
            step(1'b1);
            n++;
        end
        check(tag, pending(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, mark, n;
        int exp5_dat[8] = '{'h10, 'h11, 'h12, 'h13, 'h30, 'h31, 'h14, 'h15};
        int exp5_id[8]  = '{1, 1, 1, 1, 3, 3, 1, 1};

        req_valid = '0; req_data = '0; req_last = '0; wfull = 1'b0;

        // Reset with every requester asking, then single-word fairness.
        step(1'b0);
        chk_en = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            push_pkt(k, 1, k * 16);
            push_pkt(k, 1, k * 16 + 1);
        end
        step(1'b0);
        check("rst_winc", winc, 0);
        check("rst_ready", req_ready, 0);
        check("rst_gnt_valid", gnt_valid, 0);
        drain("fair_drain", 60);
        check("fair_n", log_id.size(), 8);
        for (int i = 0; i < log_id.size(); i++) begin
            check("fair_id", log_id[i], i % NREQ);
            if (i > 0) check("fair_gap", log_cyc[i] - log_cyc[i-1], 2);
        end

        // Single three-word packet from requester 2.
        clear_log();
        c0 = cyc;
        push_pkt(2, 3, 'hA1);
        drain("pkt_drain", 20);
        check("pkt_n", log_id.size(), 3);
        if (log_id.size() == 3) begin
            check("pkt_lat", log_cyc[0] - c0, 1);
            for (int i = 0; i < 3; i++) begin
                check("pkt_id", log_id[i], 2);
                check("pkt_dat", log_dat[i], 'hA1 + i);
                if (i > 0) check("pkt_gap", log_cyc[i] - log_cyc[i-1], 1);
            end
        end
        step(1'b1);
        check("pkt_gnt_off", gnt_valid, 0);

        // Backpressure after the first of three words.
        clear_log();
        push_pkt(1, 3, 'hB0);
        n = 0;
        while (log_id.size() < 1 && n < 10) begin step(1'b1); n++; end
        check("bp_first", log_id.size(), 1);
        force_full = 1'b1;
        repeat (5) begin
            step(1'b1);
            check("bp_winc", winc, 0);
            check("bp_ready1", req_ready[1], 0);
        end
        force_full = 1'b0;
        drain("bp_drain", 20);
        check("bp_n", log_id.size(), 3);
        if (log_id.size() == 3)
            for (int i = 0; i < 3; i++) check("bp_dat", log_dat[i], 'hB0 + i);

        // Burst cut: six words from 1 interleaved with requester 3.
        clear_log();
        push_pkt(1, 6, 'h10);
        step(1'b1);
        push_pkt(3, 2, 'h30);
        drain("cut_drain", 80);
        check("cut_n", log_id.size(), 8);
        if (log_id.size() == 8)
            for (int i = 0; i < 8; i++) begin
                check("cut_dat", log_dat[i], exp5_dat[i]);
                check("cut_id", log_id[i], exp5_id[i]);
            end

        // Reset in the middle of a four-word packet.
        clear_log();
        push_pkt(2, 4, 'hC0);
        n = 0;
        while (log_id.size() < 2 && n < 10) begin step(1'b1); n++; end
        check("mrst_pre", log_id.size(), 2);
        step(1'b0);
        mark = log_id.size();
        push_pkt(1, 1, 'h50);
        push_pkt(3, 1, 'h70);
        step(1'b1);
        check("mrst_winc", winc, 0);
        check("mrst_gnt_valid", gnt_valid, 0);
        drain("mrst_drain", 40);
        check("mrst_n", log_id.size(), mark + 3);
        if (log_id.size() > mark) check("mrst_first", log_id[mark], 1);

        // Randomized traffic with stalls, backpressure and occasional resets.
        valid_pct = 75;
        full_pct  = 25;
        repeat (1500) begin
            for (int k = 0; k < NREQ; k++)
                if (qd[k].size() < 4 && $urandom_range(7) == 0)
                    push_pkt(k, $urandom_range(7, 1), $urandom);
            step($urandom_range(199) != 0);
        end
        valid_pct = 100;
        full_pct  = 0;
        drain("rand_drain", 400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
